lock_bank: RTL and testbench

Parametrised multi-channel successor to the single-bit lock latch. Each of `CH` independent channels locks on a set request and unlocks on a clear request, an optional hold timeout, or reset. An optional post-release cooldown blocks re-locking. It sits between input/collision logic and the ship/weapon controllers, for example to latch fire requests, shield hits and pause, with rate limiting.

---
 rtl/lock_bank_pkg.sv | 25 ++
 rtl/lock_channel.sv | 130 +++++++++++++
 rtl/lock_bank.sv | 58 +++++
 tb/tb_lock_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_bank_pkg
// Purpose  : Shared state encoding and counter sizing for the lock bank.
// Revision : 1.0 - initial release
// ============================================================================
package lock_bank_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } lock_state_t;

    // One counter serves both hold and cooldown, so size it for the larger one.
    function automatic int cnt_width(input int hold_cycles, input int cool_cycles);
        int max_cycles;
        int width;
        max_cycles = (hold_cycles > cool_cycles) ? hold_cycles : cool_cycles;
        width      = $clog2(max_cycles + 1);
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_channel.sv
`default_nettype none
// ============================================================================
// Module   : lock_channel
// Purpose  : One lock channel: IDLE/LOCKED/COOLDOWN FSM with shared down-counter.
//            Define LOCK_EDGE_EN to qualify set on its rising edge only.
// Revision : 1.0 - initial release
// ============================================================================
module lock_channel
    import lock_bank_pkg::*;
#(
    parameter int HOLD_CYCLES = 0,
    parameter int COOL_CYCLES = 0,
    parameter int RETRIGGER   = 0
) (
    input  logic pclk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic locked_out,
    output logic busy_out,
    output logic release_out,
    output logic locked_next_out
);

    localparam int c_cnt_w = cnt_width(HOLD_CYCLES, COOL_CYCLES);

    localparam logic [c_cnt_w-1:0] c_hold_load =
        (HOLD_CYCLES > 0) ? c_cnt_w'(HOLD_CYCLES - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_cool_load =
        (COOL_CYCLES > 0) ? c_cnt_w'(COOL_CYCLES - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    lock_state_t          r_state;
    lock_state_t          w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_set_qual;
    logic                 w_exit;
    logic                 r_locked;
    logic                 r_busy;
    logic                 r_release;

`ifdef LOCK_EDGE_EN
    logic r_set_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_set_q <= 1'b0;
        end else begin
            r_set_q <= set_in;
        end
    end

    assign w_set_qual = set_in & ~r_set_q;
`else
    assign w_set_qual = set_in;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_exit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_set_qual && !clr_in) begin
                    w_state_nxt = LOCKED;
                    w_cnt_nxt   = c_hold_load;
                end
            end
            LOCKED: begin
                if (clr_in) begin
                    w_exit = 1'b1;
                end else if (HOLD_CYCLES > 0) begin
                    // A retrigger restarts the full hold, even on the final cycle.
                    if (w_set_qual && (RETRIGGER != 0)) begin
                        w_cnt_nxt = c_hold_load;
                    end else if (r_cnt == '0) begin
                        w_exit = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - c_one;
                    end
                end
                if (w_exit) begin
                    if (COOL_CYCLES > 0) begin
                        w_state_nxt = COOLDOWN;
                        w_cnt_nxt   = c_cool_load;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            COOLDOWN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_locked  <= 1'b0;
            r_busy    <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_locked  <= (w_state_nxt == LOCKED);
            r_busy    <= (w_state_nxt != IDLE);
            r_release <= w_exit;
        end
    end

    assign locked_out      = r_locked;
    assign busy_out        = r_busy;
    assign release_out     = r_release;
    assign locked_next_out = (w_state_nxt == LOCKED) && !rst;

endmodule
`default_nettype wire

// File: rtl/lock_bank.sv
`default_nettype none
// ============================================================================
// Module   : lock_bank
// Purpose  : CH independent lock channels with optional hold timeout/cooldown.
//            Define LOCK_EDGE_EN for rising-edge set qualification.
// Revision : 1.0 - initial release
// ============================================================================
module lock_bank
    import lock_bank_pkg::*;
#(
    parameter int CH          = 4,
    parameter int HOLD_CYCLES = 0,
    parameter int COOL_CYCLES = 0,
    parameter int RETRIGGER   = 0
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [CH-1:0] set_in,
    input  logic [CH-1:0] clr_in,
    output logic [CH-1:0] locked_out,
    output logic [CH-1:0] busy_out,
    output logic [CH-1:0] release_out,
    output logic          any_locked
);

    logic [CH-1:0] w_locked_nxt;
    logic          r_any_locked;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        lock_channel #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .COOL_CYCLES (COOL_CYCLES),
            .RETRIGGER   (RETRIGGER)
        ) u_channel (
            .pclk            (pclk),
            .rst             (rst),
            .set_in          (set_in[g]),
            .clr_in          (clr_in[g]),
            .locked_out      (locked_out[g]),
            .busy_out        (busy_out[g]),
            .release_out     (release_out[g]),
            .locked_next_out (w_locked_nxt[g])
        );
    end

    // Built from next states so it lines up with locked_out in the same cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_any_locked <= 1'b0;
        end else begin
            r_any_locked <= |w_locked_nxt;
        end
    end

    assign any_locked = r_any_locked;

endmodule
`default_nettype wire

// File: tb/tb_lock_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_bank
// Purpose  : Self-checking bench for lock_bank across five parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_bank;

    localparam int NDUT = 5;
    localparam int HP [NDUT] = '{0, 4, 4, 0, 3};
    localparam int CP [NDUT] = '{0, 0, 0, 5, 2};
    localparam int RP [NDUT] = '{0, 0, 1, 0, 0};

    logic       pclk = 1'b0;
    logic       rst_r = 1'b1;
    logic [3:0] set_r = 4'b0;
    logic [3:0] clr_r = 4'b0;
    logic [3:0] lk [NDUT];
    logic [3:0] bz [NDUT];
    logic [3:0] rl [NDUT];
    logic       an [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    lock_bank #(.CH(4), .HOLD_CYCLES(0), .COOL_CYCLES(0), .RETRIGGER(0)) u_dut0 (
        .pclk(pclk), .rst(rst_r), .set_in(set_r), .clr_in(clr_r), .locked_out(lk[0]),
        .busy_out(bz[0]), .release_out(rl[0]), .any_locked(an[0]));
    lock_bank #(.CH(4), .HOLD_CYCLES(4), .COOL_CYCLES(0), .RETRIGGER(0)) u_dut1 (
        .pclk(pclk), .rst(rst_r), .set_in(set_r), .clr_in(clr_r), .locked_out(lk[1]),
        .busy_out(bz[1]), .release_out(rl[1]), .any_locked(an[1]));
    lock_bank #(.CH(4), .HOLD_CYCLES(4), .COOL_CYCLES(0), .RETRIGGER(1)) u_dut2 (
        .pclk(pclk), .rst(rst_r), .set_in(set_r), .clr_in(clr_r), .locked_out(lk[2]),
        .busy_out(bz[2]), .release_out(rl[2]), .any_locked(an[2]));
    lock_bank #(.CH(4), .HOLD_CYCLES(0), .COOL_CYCLES(5), .RETRIGGER(0)) u_dut3 (
        .pclk(pclk), .rst(rst_r), .set_in(set_r), .clr_in(clr_r), .locked_out(lk[3]),
        .busy_out(bz[3]), .release_out(rl[3]), .any_locked(an[3]));
    lock_bank #(.CH(4), .HOLD_CYCLES(3), .COOL_CYCLES(2), .RETRIGGER(0)) u_dut4 (
        .pclk(pclk), .rst(rst_r), .set_in(set_r), .clr_in(clr_r), .locked_out(lk[4]),
        .busy_out(bz[4]), .release_out(rl[4]), .any_locked(an[4]));

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] s, input logic [3:0] c);
        rst_r = r;
        set_r = s;
        clr_r = c;
        @(posedge pclk);
        #1;
    endtask

    // Reference model: remaining locked / cooldown cycles per channel.
    // m_lock: 0 = not locked, -1 = locked with no timeout, >0 = cycles left.
    int         m_lock [NDUT][4];
    int         m_cool [NDUT][4];
    logic [3:0] m_rel  [NDUT];
    logic [3:0] m_prev = 4'b0;
    bit         m_valid = 1'b0;

    task automatic model_step();
        bit q;
        bit ex;
        for (int d = 0; d < NDUT; d++) begin
            m_rel[d] = 4'b0;
            for (int c = 0; c < 4; c++) begin
                if (rst_r) begin
                    m_lock[d][c] = 0;
                    m_cool[d][c] = 0;
                end else begin
`ifdef LOCK_EDGE_EN
                    q = set_r[c] && !m_prev[c];
`else
                    q = set_r[c];
`endif
                    ex = 1'b0;
                    if (m_lock[d][c] != 0) begin
                        if (clr_r[c]) begin
                            ex = 1'b1;
                        end else if (HP[d] > 0) begin
                            if (q && RP[d] == 1) begin
                                m_lock[d][c] = HP[d];
                            end else begin
                                m_lock[d][c] = m_lock[d][c] - 1;
                                ex = (m_lock[d][c] == 0);
                            end
                        end
                        if (ex) begin
                            m_lock[d][c] = 0;
                            m_rel[d][c]  = 1'b1;
                            m_cool[d][c] = CP[d];
                        end
                    end else if (m_cool[d][c] > 0) begin
                        m_cool[d][c] = m_cool[d][c] - 1;
                    end else if (q && !clr_r[c]) begin
                        m_lock[d][c] = (HP[d] > 0) ? HP[d] : -1;
                    end
                end
            end
        end
        m_prev = rst_r ? 4'b0 : set_r;
        if (rst_r) m_valid = 1'b1;
    endtask

    function automatic logic [3:0] exp_lk(input int d);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = (m_lock[d][c] != 0);
        return v;
    endfunction

    function automatic logic [3:0] exp_bz(input int d);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = (m_lock[d][c] != 0) || (m_cool[d][c] > 0);
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge pclk);
            model_step();
            #1;
            if (m_valid) begin
                for (int d = 0; d < NDUT; d++) begin
                    check($sformatf("model_locked_d%0d", d), lk[d], exp_lk(d));
                    check($sformatf("model_busy_d%0d", d), bz[d], exp_bz(d));
                    check($sformatf("model_release_d%0d", d), rl[d], m_rel[d]);
                    check($sformatf("model_any_d%0d", d), {3'b0, an[d]}, {3'b0, |exp_lk(d)});
                end
            end
        end
    end

    typedef struct {
        logic       r;
        logic [3:0] s;
        logic [3:0] c;
        logic [3:0] lk;
        logic [3:0] bz;
        logic [3:0] rl;
        logic       an;
    } vec_t;

    vec_t vt [15];

    initial begin
        int n;
        int nb;
        int nc;
        int nl;
        logic prev;
        logic [3:0] s;
        logic [3:0] c;

        // Basic lock on the HOLD=COOL=0 instance.
        vt[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vt[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vt[2]  = '{1'b0, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1};
        vt[3]  = '{1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1};
        vt[4]  = '{1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1};
        vt[5]  = '{1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1};
        vt[6]  = '{1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1};
        vt[7]  = '{1'b0, 4'h0, 4'h1, 4'h4, 4'h4, 4'h1, 1'b1};
        vt[8]  = '{1'b0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 1'b1};
        vt[9]  = '{1'b0, 4'h2, 4'h2, 4'h4, 4'h4, 4'h0, 1'b1};
        vt[10] = '{1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0};
        vt[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vt[12] = '{1'b0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 1'b1};
        vt[13] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vt[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].r, vt[i].s, vt[i].c);
            check($sformatf("vec%0d_locked", i), lk[0], vt[i].lk);
            check($sformatf("vec%0d_busy", i), bz[0], vt[i].bz);
            check($sformatf("vec%0d_release", i), rl[0], vt[i].rl);
            check($sformatf("vec%0d_any", i), {3'b0, an[0]}, {3'b0, vt[i].an});
        end

        // Hold timeout, HOLD=3 instance.
        cyc(1'b1, 4'h0, 4'h0);
        cyc(1'b0, 4'h1, 4'h0);
        n = lk[4][0] ? 1 : 0;
        for (int i = 0; i < 20 && lk[4][0]; i++) begin
            cyc(1'b0, 4'h0, 4'h0);
            if (lk[4][0]) n++;
        end
        check_int("hold_locked_cycles", n, 3);
        check("hold_release_pulse", {3'b0, rl[4][0]}, 4'b0001);
        cyc(1'b0, 4'h0, 4'h0);
        check("hold_release_single", {3'b0, rl[4][0]}, 4'b0000);

        // Retrigger: second set two cycles after the first.
        cyc(1'b1, 4'h0, 4'h0);
        nb = 0;
        nc = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, (i == 0 || i == 2) ? 4'h1 : 4'h0, 4'h0);
            nb += lk[1][0] ? 1 : 0;
            nc += lk[2][0] ? 1 : 0;
        end
        check_int("retrigger_on_cycles", nc, 6);
        check_int("retrigger_off_cycles", nb, 4);

        // Cooldown of 5 with a set attempted on every cooldown cycle.
        cyc(1'b1, 4'h0, 4'h0);
        cyc(1'b0, 4'h1, 4'h0);
        check("cool_lock", {3'b0, lk[3][0]}, 4'b0001);
        cyc(1'b0, 4'h0, 4'h1);
        check("cool_clear_locked", {3'b0, lk[3][0]}, 4'b0000);
        check("cool_clear_release", {3'b0, rl[3][0]}, 4'b0001);
        nb = bz[3][0] ? 1 : 0;
        nl = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'h1, 4'h0);
            nb += bz[3][0] ? 1 : 0;
            nl += lk[3][0] ? 1 : 0;
        end
        cyc(1'b0, 4'h1, 4'h0);
        check("cool_end_busy", {3'b0, bz[3][0]}, 4'b0000);
        check("cool_end_locked", {3'b0, lk[3][0]}, 4'b0000);
        check_int("cool_busy_cycles", nb, 5);
        check_int("cool_relocks", nl, 0);
`ifdef LOCK_EDGE_EN
        cyc(1'b0, 4'h0, 4'h0);
`endif
        cyc(1'b0, 4'h1, 4'h0);
        check("cool_relock_after", {3'b0, lk[3][0]}, 4'b0001);

        // Set held high for 20 cycles, HOLD=3 COOL=2.
        cyc(1'b1, 4'h0, 4'h0);
        n = 0;
        prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, (i < 20) ? 4'h1 : 4'h0, 4'h0);
            if (lk[4][0] && !prev) n++;
            prev = lk[4][0];
        end
`ifdef LOCK_EDGE_EN
        check_int("held_set_lock_count", n, 1);
`else
        check_int("held_set_lock_count", n, 4);
`endif

        // Random traffic, checked by the model on every cycle.
        cyc(1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                s[b] = ($urandom_range(0, 99) < 25);
                c[b] = ($urandom_range(0, 99) < 12);
            end
            cyc(($urandom_range(0, 39) == 0), s, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
